pwm_led_array: RTL and testbench

Parametrised multi-channel PWM LED driver and successor to the single fixed-duty blinker. All channels share one free-running period counter. Each channel has its own duty register, updated glitch-free at period boundaries, and can run in either static-duty mode or an autonomous "breathing" ramp mode. It sits between the board-control register logic and the LED pins.

---
 rtl/pwm_led_array_pkg.sv | 10 +
 rtl/pwm_led_ch.sv | 91 +++++++++
 rtl/pwm_led_array.sv | 59 +++++
 tb/tb_pwm_led_array.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_led_array_pkg.sv
// rtl/pwm_led_array_pkg.sv - shared encodings for the PWM LED array
package pwm_led_array_pkg;

  localparam logic [0:0] RAMP_UP     = 1'b0;
  localparam logic [0:0] RAMP_DOWN   = 1'b1;

  localparam logic [0:0] MODE_STATIC = 1'b0;
  localparam logic [0:0] MODE_BREATH = 1'b1;

endpackage

// File: rtl/pwm_led_ch.sv
// rtl/pwm_led_ch.sv - one PWM channel: duty capture, boundary update, breathing ramp, compare
module pwm_led_ch
  import pwm_led_array_pkg::*;
#(
  parameter int CNT_W  = 17,
  parameter int PERIOD = 90000,
  parameter int STEP   = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             boundary,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_wr,
  input  logic             mode,
  output logic             led
);

  // Duties run one bit wider than cnt so that a duty of exactly PERIOD (up to 2^CNT_W) fits.
  localparam logic [CNT_W:0]   DUTY_MAX = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W+1:0] PERIOD_X = (CNT_W+2)'(PERIOD);
  localparam logic [CNT_W+1:0] STEP_X   = (CNT_W+2)'(STEP);

  logic [CNT_W:0]   duty_clamped;
  logic [CNT_W:0]   pending;
  logic [CNT_W:0]   active;
  logic [CNT_W:0]   ramp;
  logic [CNT_W:0]   eff_duty;
  logic [CNT_W+1:0] ramp_ext;
  logic [CNT_W+1:0] ramp_sum;
  logic             ramp_state;
  logic             mode_q;

  assign duty_clamped = ({1'b0, duty_in} > DUTY_MAX) ? DUTY_MAX : {1'b0, duty_in};
  assign ramp_ext     = {1'b0, ramp};
  assign ramp_sum     = ramp_ext + STEP_X;
  assign eff_duty     = (mode_q == MODE_BREATH) ? ramp : active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      active  <= '0;
    end else begin
      if (duty_wr) begin
        pending <= duty_clamped;
      end
      // A write landing on the boundary itself goes straight to the next period.
      if (boundary) begin
        active <= duty_wr ? duty_clamped : pending;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp       <= '0;
      ramp_state <= RAMP_UP;
      mode_q     <= MODE_STATIC;
    end else if (boundary) begin
      mode_q <= mode;
      if (mode == MODE_STATIC) begin
        ramp       <= '0;
        ramp_state <= RAMP_UP;
      end else if (ramp_state == RAMP_UP) begin
        if (ramp_sum >= PERIOD_X) begin
          ramp       <= DUTY_MAX;
          ramp_state <= RAMP_DOWN;
        end else begin
          ramp <= ramp_sum[CNT_W:0];
        end
      end else begin
        if (ramp_ext <= STEP_X) begin
          ramp       <= '0;
          ramp_state <= RAMP_UP;
        end else begin
          ramp <= ramp - STEP_X[CNT_W:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b0;
    end else begin
      led <= en && ({1'b0, cnt} < eff_duty);
    end
  end

endmodule

// File: rtl/pwm_led_array.sv
// rtl/pwm_led_array.sv - multi-channel PWM LED driver sharing one period counter
module pwm_led_array
  import pwm_led_array_pkg::*;
#(
  parameter int CH     = 4,
  parameter int CNT_W  = 17,
  parameter int PERIOD = 90000,
  parameter int STEP   = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CH*CNT_W-1:0] duty_in,
  input  logic [CH-1:0]       duty_wr,
  input  logic [CH-1:0]       mode,
  output logic [CH-1:0]       led,
  output logic                period_end
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             boundary;

  assign boundary = en && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      period_end <= 1'b0;
    end else begin
      period_end <= boundary;
      if (!en || boundary) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_led_ch #(
      .CNT_W  (CNT_W),
      .PERIOD (PERIOD),
      .STEP   (STEP)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .boundary (boundary),
      .cnt      (cnt),
      .duty_in  (duty_in[i*CNT_W +: CNT_W]),
      .duty_wr  (duty_wr[i]),
      .mode     (mode[i]),
      .led      (led[i])
    );
  end

endmodule

// File: tb/tb_pwm_led_array.sv
// tb/tb_pwm_led_array.sv - randomized and directed bench against a period-level reference model
module tb_pwm_led_array;

  localparam int CH     = 4;
  localparam int CNT_W  = 5;
  localparam int PERIOD = 10;
  localparam int STEP   = 3;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic [CH*CNT_W-1:0] duty_in;
  logic [CH-1:0]       duty_wr;
  logic [CH-1:0]       mode;
  logic [CH-1:0]       led;
  logic                period_end;

  pwm_led_array #(
    .CH(CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .duty_in(duty_in), .duty_wr(duty_wr),
    .mode(mode), .led(led), .period_end(period_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the breathing waveform is a precomputed triangle indexed per period.
  int seq[$];
  int m_cnt;
  int m_pend[CH];
  int m_act[CH];
  int m_bidx[CH];
  bit m_breath[CH];
  int hc[CH];
  int pc[CH][64];
  int pn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic build_seq();
    int v;
    v = 0;
    seq.push_back(0);
    while (v < PERIOD) begin
      v = v + STEP;
      if (v > PERIOD) v = PERIOD;
      seq.push_back(v);
    end
    while (v > STEP) begin
      v = v - STEP;
      seq.push_back(v);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0;
    pn = 0;
    for (int i = 0; i < CH; i++) begin
      m_pend[i] = 0; m_act[i] = 0; m_bidx[i] = 0; m_breath[i] = 0; hc[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_led", 32'(led), 32'd0);
    check("rst_period_end", 32'(period_end), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_duty(input int ch, input int val);
    duty_in[ch*CNT_W +: CNT_W] = CNT_W'(val);
    duty_wr[ch] = 1'b1;
  endtask

  // One clock: predict, clock, compare, advance the model.
  task automatic cycle();
    logic [CH-1:0] exp_led;
    bit bnd;
    int eff, val;
    bnd = en && (m_cnt == PERIOD - 1);
    for (int i = 0; i < CH; i++) begin
      eff = m_breath[i] ? seq[m_bidx[i]] : m_act[i];
      exp_led[i] = en && (m_cnt < eff);
    end
    @(posedge clk);
    #1;
    check("led", 32'(led), 32'(exp_led));
    check("period_end", 32'(period_end), 32'(bnd));
    for (int i = 0; i < CH; i++) begin
      if (duty_wr[i]) begin
        val = int'(duty_in[i*CNT_W +: CNT_W]);
        m_pend[i] = (val > PERIOD) ? PERIOD : val;
      end
      if (bnd) begin
        m_act[i] = m_pend[i];
        m_breath[i] = mode[i];
        m_bidx[i] = mode[i] ? (m_bidx[i] + 1) % seq.size() : 0;
      end
      hc[i] += int'(led[i]);
    end
    m_cnt = (!en || bnd) ? 0 : m_cnt + 1;
    if (period_end) begin
      for (int i = 0; i < CH; i++) begin
        if (pn < 64) pc[i][pn] = hc[i];
        hc[i] = 0;
      end
      pn++;
    end
    duty_wr = '0;
  endtask

  task automatic run_until_pn(input int target);
    int n;
    n = 0;
    while (pn < target && n < 400) begin
      cycle();
      n++;
    end
    check("wait_periods", 32'(pn >= target), 32'd1);
  endtask

  task automatic run_until_cnt(input int target);
    int n;
    n = 0;
    while (m_cnt != target && n < 50) begin
      cycle();
      n++;
    end
    check("wait_cnt", 32'(m_cnt), 32'(target));
  endtask

  int exp_breath[9] = '{3, 6, 9, 10, 7, 4, 1, 0, 3};
  int k;

  initial begin
    rst_n = 1'b0; en = 1'b0; duty_in = '0; duty_wr = '0; mode = '0;
    build_seq();
    model_clear();
    #12;
    do_reset();

    // Multi-channel: static 0/3/10 with channel 2 breathing.
    en = 1'b1;
    mode = 4'b0100;
    set_duty(0, 0); set_duty(1, 3); set_duty(2, 5); set_duty(3, 10);
    run_until_pn(11);
    for (int p = 0; p < 9; p++) check("breath_highs", 32'(pc[2][p+1]), 32'(exp_breath[p]));
    check("ch0_highs", 32'(pc[0][2]), 32'd0);
    check("ch1_highs", 32'(pc[1][2]), 32'd3);
    check("ch3_highs", 32'(pc[3][2]), 32'd10);
    check("ch3_first", 32'(pc[3][0]), 32'd0);

    // Asynchronous reset in the middle of a period.
    run_until_cnt(5);
    do_reset();

    // Glitch-free update: duty 7 written mid-period does not touch the current duty-2 period.
    en = 1'b1;
    mode = '0;
    set_duty(0, 2);
    cycle();
    run_until_pn(1);
    run_until_cnt(3);
    set_duty(0, 7);
    cycle();
    run_until_pn(3);
    check("glitch_cur", 32'(pc[0][1]), 32'd2);
    check("glitch_next", 32'(pc[0][2]), 32'd7);

    // Boundary bypass with clamp, then duty 0.
    run_until_cnt(PERIOD - 1);
    set_duty(1, 15);
    cycle();
    k = pn;
    run_until_pn(k + 1);
    check("bypass_clamp", 32'(pc[1][k]), 32'd10);
    run_until_cnt(PERIOD - 1);
    set_duty(1, 0);
    cycle();
    k = pn;
    run_until_pn(k + 1);
    check("duty_zero", 32'(pc[1][k]), 32'd0);

    // Enable drop mid-period.
    set_duty(3, 10);
    run_until_pn(pn + 1);
    run_until_cnt(4);
    en = 1'b0;
    cycle();
    check("en_off_led", 32'(led), 32'd0);
    for (int n = 0; n < 12; n++) cycle();
    en = 1'b1;

    // Randomized traffic with an asynchronous reset partway through.
    for (int n = 0; n < 1500; n++) begin
      en = ($urandom_range(0, 29) != 0);
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 7) == 0) set_duty(i, int'($urandom_range(0, 31)));
      end
      if ($urandom_range(0, 39) == 0) mode = CH'($urandom);
      if (n == 700) begin
        #2;
        do_reset();
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
